fifo_stream_reader: RTL and testbench

//  Drain side of the pixel FIFO. Pops pixels from a first-word-fall-through FIFO and re-times them

---
 rtl/fifo_stream_reader_pkg.sv | 32 +++
 rtl/fifo_stream_reader_pixel_position_counter.sv | 43 ++++
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 tb/tb_fifo_stream_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the pixel FIFO drain path: FSM encoding, default frame geometry
// and the stream FSM next-state function.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;

  // frame_idle: next beat is x=y=0 and nothing of the current frame is left to hand over.
  function automatic state_t fsm_next(
    input state_t cur,
    input logic   enable,
    input logic   at_origin,
    input logic   frame_idle
  );
    state_t nxt;
    nxt = IDLE;
    case (cur)
      IDLE:    nxt = (enable && at_origin) ? ACTIVE : IDLE;
      ACTIVE:  nxt = enable ? ACTIVE : (frame_idle ? IDLE : DRAIN);
      DRAIN:   nxt = enable ? ACTIVE : (frame_idle ? IDLE : DRAIN);
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_pixel_position_counter.sv
// Raster position of the next pixel: x/y counters with wrap and first/last flags.
// Shared between the FIFO reader and writer sides.
module pixel_position_counter #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ADVANCE,
  output logic [COUNT_WIDTH-1:0] X,
  output logic                   IS_FIRST,
  output logic                   IS_LAST_X,
  output logic                   IS_LAST_Y
);

  localparam logic [COUNT_WIDTH-1:0] LAST_X = COUNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_Y = COUNT_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] x_reg;
  logic [COUNT_WIDTH-1:0] y_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (ADVANCE) begin
      if (x_reg == LAST_X) begin
        x_reg <= '0;
        y_reg <= (y_reg == LAST_Y) ? '0 : y_reg + ONE;
      end else begin
        x_reg <= x_reg + ONE;
      end
    end
  end

  assign X         = x_reg;
  assign IS_FIRST  = (x_reg == '0) && (y_reg == '0);
  assign IS_LAST_X = (x_reg == LAST_X);
  assign IS_LAST_Y = (y_reg == LAST_Y);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through pixel FIFO into a valid/ready video stream with
// start-of-frame and end-of-line markers, stopping only on frame boundaries.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [DATA_WIDTH-1:0]  FIFO_DATA,
  input  logic                   FIFO_EMPTY,
  output logic                   FIFO_READ,
  output logic [DATA_WIDTH-1:0]  M_DATA,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic                   M_USER,
  output logic                   M_LAST,
  output logic                   FRAME_DONE,
  output logic                   BUSY,
  output logic [COUNT_WIDTH-1:0] UNDERFLOW_COUNT
);

  state_t                 state_reg;
  state_t                 state_next;
  logic [DATA_WIDTH-1:0]  m_data_reg;
  logic                   m_valid_reg;
  logic                   m_user_reg;
  logic                   m_last_reg;
  logic                   last_line_reg;
  logic                   frame_done_reg;
  logic [COUNT_WIDTH-1:0] underflow_reg;

  logic [COUNT_WIDTH-1:0] pos_x;
  logic                   pos_first;
  logic                   pos_last_x;
  logic                   pos_last_y;

  logic slot_free;
  logic accept;
  logic frame_end;
  logic frame_idle;
  logic start_ok;
  logic load;
  logic underflow;

  pixel_position_counter #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_position (
    .CLK       (CLK),
    .RESET     (RESET),
    .ADVANCE   (load),
    .X         (pos_x),
    .IS_FIRST  (pos_first),
    .IS_LAST_X (pos_last_x),
    .IS_LAST_Y (pos_last_y)
  );

  assign slot_free  = !m_valid_reg || M_READY;
  assign accept     = m_valid_reg && M_READY;
  assign frame_end  = accept && m_last_reg && last_line_reg;
  // A beat held while the position sits at the origin is always the last of its frame.
  assign frame_idle = pos_first && (!m_valid_reg || accept);
  // The first pixel of a frame is only taken while streaming is requested.
  assign start_ok   = ENABLE || !pos_first;
  assign load       = (state_reg != IDLE) && !FIFO_EMPTY && slot_free && start_ok;
  assign underflow  = (state_reg != IDLE) && FIFO_EMPTY && slot_free && (pos_x != '0);
  assign state_next = fsm_next(state_reg, ENABLE, pos_first, frame_idle);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= IDLE;
      m_data_reg     <= '0;
      m_valid_reg    <= 1'b0;
      m_user_reg     <= 1'b0;
      m_last_reg     <= 1'b0;
      last_line_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      underflow_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= frame_end;
      if (load) begin
        m_data_reg    <= FIFO_DATA;
        m_valid_reg   <= 1'b1;
        m_user_reg    <= pos_first;
        m_last_reg    <= pos_last_x;
        last_line_reg <= pos_last_y;
      end else if (accept) begin
        m_valid_reg <= 1'b0;
      end
      if (underflow && (underflow_reg != {COUNT_WIDTH{1'b1}})) begin
        underflow_reg <= underflow_reg + COUNT_WIDTH'(1);
      end
    end
  end

  assign FIFO_READ       = load;
  assign M_DATA          = m_data_reg;
  assign M_VALID         = m_valid_reg;
  assign M_USER          = m_user_reg;
  assign M_LAST          = m_last_reg;
  assign FRAME_DONE      = frame_done_reg;
  assign BUSY            = (state_reg != IDLE);
  assign UNDERFLOW_COUNT = underflow_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader on a 4x2 frame with a modelled FWFT FIFO and
// a scoreboard of expected beats; a second 4-bit-counter instance covers saturation.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int CW = 16;
  localparam int PIX = FW * FH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    logic          frame_last;
  } beat_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET;
  logic          ENABLE;
  logic          M_READY;
  logic          flush;
  logic [DW-1:0] FIFO_DATA;
  logic          FIFO_EMPTY;
  logic          FIFO_READ;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_USER;
  logic          M_LAST;
  logic          FRAME_DONE;
  logic          BUSY;
  logic [CW-1:0] UNDERFLOW_COUNT;

  logic [DW-1:0] fifo_mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;

  assign FIFO_EMPTY = (rd_ptr == wr_ptr);
  assign FIFO_DATA  = fifo_mem[rd_ptr[5:0]];

  always @(posedge CLK) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (FIFO_READ) rd_ptr <= rd_ptr + 1;
  end

  fifo_stream_reader #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COUNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_READ(FIFO_READ),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .M_USER(M_USER), .M_LAST(M_LAST), .FRAME_DONE(FRAME_DONE),
    .BUSY(BUSY), .UNDERFLOW_COUNT(UNDERFLOW_COUNT)
  );

  // Saturation instance with a narrow counter and its own FIFO flag.
  logic          sat_en;
  logic          sat_empty;
  logic          sat_ready;
  logic [DW-1:0] sat_data;
  logic          sat_fifo_read;
  logic [DW-1:0] sat_m_data;
  logic          sat_m_valid;
  logic          sat_m_user;
  logic          sat_m_last;
  logic          sat_frame_done;
  logic          sat_busy;
  logic [3:0]    sat_underflow;

  fifo_stream_reader #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COUNT_WIDTH(4)
  ) dut_sat (
    .CLK(CLK), .RESET(RESET), .ENABLE(sat_en),
    .FIFO_DATA(sat_data), .FIFO_EMPTY(sat_empty), .FIFO_READ(sat_fifo_read),
    .M_DATA(sat_m_data), .M_VALID(sat_m_valid), .M_READY(sat_ready),
    .M_USER(sat_m_user), .M_LAST(sat_m_last), .FRAME_DONE(sat_frame_done),
    .BUSY(sat_busy), .UNDERFLOW_COUNT(sat_underflow)
  );

  beat_t exp_q[$];
  int vec_cnt = 0;
  int miss_cnt = 0;
  int frame_done_seen = 0;
  logic done_due = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int idx);
    beat_t b;
    b.data       = d;
    b.user       = (idx % PIX == 0);
    b.last       = (idx % FW == FW - 1);
    b.frame_last = (idx % PIX == PIX - 1);
    exp_q.push_back(b);
  endtask

  task automatic push_fifo(input logic [DW-1:0] d);
    fifo_mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input int idx);
    push_fifo(d);
    push_exp(d, idx);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (exp_q.size() == 0) break;
    end
    check("drain_bound", exp_q.size(), 0);
  endtask

  task automatic wait_fifo_empty(input int limit);
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (rd_ptr == wr_ptr) break;
    end
    check("fifo_empty_bound", wr_ptr - rd_ptr, 0);
  endtask

  // Monitor: one line per accepted beat, scoreboard compare, FRAME_DONE timing.
  always begin
    beat_t e;
    @(negedge CLK);
    #1;
    if (RESET !== 1'b1) begin
      done_due = 1'b0;
    end else begin
      check("frame_done", FRAME_DONE, done_due);
      if (FRAME_DONE === 1'b1) frame_done_seen++;
      done_due = 1'b0;
      if (M_VALID && !M_READY) check("stall_read", FIFO_READ, 0);
      if (M_VALID && M_READY) begin
        vec_cnt++;
        assert (exp_q.size() != 0) else begin
          miss_cnt++;
          $error("FAIL extra_beat observed=%0h expected=none", M_DATA);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("beat data=%0h user=%0b last=%0b", M_DATA, M_USER, M_LAST);
          check("beat_data", M_DATA, e.data);
          check("beat_user", M_USER, e.user);
          check("beat_last", M_LAST, e.last);
          done_due = e.frame_last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    RESET = 1'b0; ENABLE = 1'b0; M_READY = 1'b1; flush = 1'b0;
    sat_en = 1'b0; sat_empty = 1'b1; sat_ready = 1'b1; sat_data = 32'hCAFE0000;

    // Reset state
    repeat (3) cyc();
    #2;
    check("rst_valid", M_VALID, 0);
    check("rst_data", M_DATA, 0);
    check("rst_user", M_USER, 0);
    check("rst_last", M_LAST, 0);
    check("rst_done", FRAME_DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_underflow", UNDERFLOW_COUNT, 0);
    check("rst_read", FIFO_READ, 0);
    cyc();
    RESET = 1'b1;

    // Full frame, words 0..7, full throughput
    for (int i = 0; i < PIX; i++) push_word(DW'(i), i);
    cyc();
    ENABLE = 1'b1;
    cyc(); #2;
    check("busy_after_enable", BUSY, 1);
    check("valid_latency", M_VALID, 0);
    for (int i = 0; i < PIX; i++) begin
      cyc(); #2;
      check("stream_valid", M_VALID, 1);
    end
    wait_drain(20);
    repeat (2) cyc();
    check("frames_after_full", frame_done_seen, 1);

    // Backpressure 1,0,0 repeating
    for (int i = 0; i < PIX; i++) push_word(32'h100 + DW'(i), i);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (exp_q.size() == 0) break;
      M_READY = (c % 3 == 0);
      c++;
    end
    M_READY = 1'b1;
    check("bp_drain_bound", exp_q.size(), 0);
    repeat (3) cyc();
    check("frames_after_bp", frame_done_seen, 2);
    check("underflow_none", UNDERFLOW_COUNT, 0);

    // Underflow mid-line (3 cycles) then empty at x=0 (5 cycles)
    push_word(32'h200, 0);
    push_word(32'h201, 1);
    wait_fifo_empty(40);
    repeat (3) cyc();
    push_word(32'h202, 2);
    push_word(32'h203, 3);
    #2;
    check("underflow_mid", UNDERFLOW_COUNT, 3);
    wait_fifo_empty(40);
    repeat (5) cyc();
    for (int i = 4; i < PIX; i++) push_word(32'h200 + DW'(i), i);
    #2;
    check("underflow_x0", UNDERFLOW_COUNT, 3);
    wait_drain(40);
    repeat (2) cyc();
    check("underflow_after", UNDERFLOW_COUNT, 3);
    check("frames_after_uf", frame_done_seen, 3);

    // Drain: ENABLE drops after word 2 with 12 words queued
    base = wr_ptr;
    for (int i = 0; i < PIX; i++) push_word(32'h300 + DW'(i), i);
    for (int i = PIX; i < 12; i++) push_fifo(32'h300 + DW'(i));
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (rd_ptr >= base + 3) break;
    end
    ENABLE = 1'b0;
    wait_drain(40);
    repeat (4) cyc();
    #2;
    check("drain_busy", BUSY, 0);
    check("drain_left", wr_ptr - rd_ptr, 4);
    check("drain_read", FIFO_READ, 0);
    check("drain_valid", M_VALID, 0);
    check("frames_after_drain", frame_done_seen, 4);

    // Reset mid-stream: leftover words form a new frame, cut short by reset
    for (int i = 0; i < 4; i++) push_exp(32'h308 + DW'(i), i);
    cyc();
    ENABLE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #2;
      if (M_VALID === 1'b1) break;
    end
    check("pre_reset_valid", M_VALID, 1);
    cyc();
    RESET = 1'b0;
    flush = 1'b1;
    ENABLE = 1'b0;
    #2;
    check("mid_rst_valid", M_VALID, 0);
    check("mid_rst_read", FIFO_READ, 0);
    check("mid_rst_data", M_DATA, 0);
    check("mid_rst_user", M_USER, 0);
    check("mid_rst_last", M_LAST, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_underflow", UNDERFLOW_COUNT, 0);
    exp_q.delete();
    cyc();
    flush = 1'b0;
    RESET = 1'b1;
    for (int i = 0; i < PIX; i++) push_word(32'h500 + DW'(i), i);
    cyc();
    ENABLE = 1'b1;
    wait_drain(40);
    repeat (2) cyc();
    check("frames_after_reset", frame_done_seen, 5);
    check("underflow_after_reset", UNDERFLOW_COUNT, 0);
    ENABLE = 1'b0;

    // Saturation on the 4-bit instance: one word then 25 mid-line empty cycles
    cyc();
    sat_en = 1'b1;
    cyc();
    sat_empty = 1'b0;
    cyc();
    sat_empty = 1'b1;
    repeat (10) cyc();
    #2;
    check("sat_count_10", sat_underflow, 10);
    repeat (15) cyc();
    #2;
    check("sat_count_hold", sat_underflow, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
